// File: rtl/decompress_defines_pkg.sv
// Shared types, constants and helpers for the MLKEM decompress sequencer.
package decompress_defines_pkg;

    localparam int ABR_MEM_ADDR_WIDTH = 14;
    localparam int DECOMP_MAX_TOTAL   = 176;
    localparam int DECOMP_CNT_W       = 8;

    typedef enum logic [2:0] {
        DMODE_D1  = 3'd0,
        DMODE_D4  = 3'd1,
        DMODE_D5  = 3'd2,
        DMODE_D10 = 3'd3,
        DMODE_D11 = 3'd4
    } decomp_dmode_e;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_ARM,
        SEQ_STREAM,
        SEQ_DRAIN,
        SEQ_WAIT_DONE
    } decomp_seq_state_e;

    // Packed 64-bit words per polynomial: 256 coeffs * d bits / 64
    function automatic logic [DECOMP_CNT_W-1:0] decomp_wpp(input logic [2:0] mode);
        case (mode)
            DMODE_D1:  return 8'd4;
            DMODE_D4:  return 8'd16;
            DMODE_D5:  return 8'd20;
            DMODE_D10: return 8'd40;
            DMODE_D11: return 8'd44;
            default:   return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/decompress_seq_fifo.sv
// Small synchronous FIFO holding read data returned ahead of datapath demand.
module decompress_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/decompress_seq_ctrl.sv
// Sequences one MLKEM decompress job: arm write control, stream source words, await completion.
module decompress_seq_ctrl
    import decompress_defines_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          zeroize,
    input  logic                          start,
    input  logic [2:0]                    num_poly,
    input  logic [2:0]                    d_mode,
    input  logic [ABR_MEM_ADDR_WIDTH-1:0] src_base_addr,
    input  logic [ABR_MEM_ADDR_WIDTH-1:0] dest_base_addr,
    output logic                          mem_rd_req,
    output logic [ABR_MEM_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [63:0]                   mem_rd_data,
    output logic                          dp_enable,
    output logic [ABR_MEM_ADDR_WIDTH-1:0] dp_dest_addr,
    output logic [63:0]                   dp_data,
    output logic                          dp_valid,
    input  logic                          dp_ready,
    input  logic                          dp_done,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = ABR_MEM_ADDR_WIDTH;

    decomp_seq_state_e     state, state_nxt;
    logic [DECOMP_CNT_W-1:0] total_q, issued_q, sent_q;
    logic [AW-1:0]         src_q, dest_q;
    logic [RD_LATENCY-1:0] pipe;
    logic [RD_LATENCY:0]   pipe_nxt;
    logic [CW-1:0]         inflight, fifo_count;
    logic [63:0]           fifo_rdata;
    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic                  legal, accept, bad_cmd, proto_err, flush;
    logic                  rd_ret, credit_ok, last_req, xfer;

    assign legal     = (num_poly != 3'd0) && (num_poly <= 3'd4) && (d_mode <= 3'd4);
    assign accept    = (state == SEQ_IDLE) && start && legal;
    assign bad_cmd   = (state == SEQ_IDLE) && start && !legal;
    assign proto_err = dp_done && ((state == SEQ_STREAM) || (state == SEQ_DRAIN));
    assign flush     = zeroize || proto_err;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(pipe[i]);
    end

    // Words in flight plus buffered words never exceed the FIFO depth
    assign credit_ok  = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
    assign mem_rd_req = (state == SEQ_STREAM) && (issued_q < total_q) && credit_ok && !fifo_full;
    assign mem_rd_addr = mem_rd_req ? src_q + AW'(issued_q) : '0;
    assign last_req   = mem_rd_req && ((issued_q + 1'b1) == total_q);

    assign pipe_nxt = {pipe, mem_rd_req};
    assign rd_ret   = pipe[RD_LATENCY-1];

    // Returning data bypasses an empty FIFO so the first word costs no extra cycle
    assign dp_valid  = !fifo_empty || rd_ret;
    assign dp_data   = !fifo_empty ? fifo_rdata : (rd_ret ? mem_rd_data : '0);
    assign xfer      = dp_valid && dp_ready;
    assign fifo_pop  = !fifo_empty && dp_ready;
    assign fifo_push = rd_ret && !(fifo_empty && dp_ready);

    assign dp_enable    = (state == SEQ_ARM);
    assign dp_dest_addr = dest_q;
    assign busy         = (state != SEQ_IDLE);

    decompress_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (mem_rd_data),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            SEQ_IDLE:      if (accept) state_nxt = SEQ_ARM;
            SEQ_ARM:       state_nxt = SEQ_STREAM;
            SEQ_STREAM: begin
                if (proto_err)     state_nxt = SEQ_IDLE;
                else if (last_req) state_nxt = SEQ_DRAIN;
            end
            SEQ_DRAIN: begin
                if (proto_err)              state_nxt = SEQ_IDLE;
                else if (sent_q == total_q) state_nxt = SEQ_WAIT_DONE;
            end
            SEQ_WAIT_DONE: if (dp_done) state_nxt = SEQ_IDLE;
            default:       state_nxt = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     state <= SEQ_IDLE;
        else if (zeroize) state <= SEQ_IDLE;
        else              state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe <= '0;
        end else if (flush) begin
            pipe <= '0;
        end else begin
            pipe <= pipe_nxt[RD_LATENCY-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            total_q  <= '0;
            issued_q <= '0;
            sent_q   <= '0;
            src_q    <= '0;
            dest_q   <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else if (zeroize) begin
            total_q  <= '0;
            issued_q <= '0;
            sent_q   <= '0;
            src_q    <= '0;
            dest_q   <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            done  <= (state == SEQ_WAIT_DONE) && dp_done;
            error <= bad_cmd || proto_err;
            if (accept) begin
                total_q  <= DECOMP_CNT_W'(num_poly) * decomp_wpp(d_mode);
                issued_q <= '0;
                sent_q   <= '0;
                src_q    <= src_base_addr;
                dest_q   <= dest_base_addr;
            end else begin
                if (mem_rd_req) issued_q <= issued_q + 1'b1;
                if (xfer)       sent_q   <= sent_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decompress_seq_ctrl.sv
// Directed-plus-random bench for decompress_seq_ctrl against a word-stream reference model.
module tb_decompress_seq_ctrl;
    import decompress_defines_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int AW    = ABR_MEM_ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          zeroize = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    num_poly = '0;
    logic [2:0]    d_mode = '0;
    logic [AW-1:0] src_base_addr = '0;
    logic [AW-1:0] dest_base_addr = '0;
    logic          mem_rd_req;
    logic [AW-1:0] mem_rd_addr;
    logic [63:0]   mem_rd_data;
    logic          dp_enable;
    logic [AW-1:0] dp_dest_addr;
    logic [63:0]   dp_data;
    logic          dp_valid;
    logic          dp_ready = 1'b0;
    logic          dp_done = 1'b0;
    logic          busy, done, error;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rdy_pct = 100;

    decompress_seq_ctrl #(.RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .start(start),
        .num_poly(num_poly), .d_mode(d_mode),
        .src_base_addr(src_base_addr), .dest_base_addr(dest_base_addr),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .dp_enable(dp_enable), .dp_dest_addr(dp_dest_addr),
        .dp_data(dp_data), .dp_valid(dp_valid), .dp_ready(dp_ready),
        .dp_done(dp_done), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] fdata(input logic [AW-1:0] a);
        logic [31:0] x;
        x = 32'(a);
        return {x ^ 32'hA5A5_0000, x * 32'h9E37_79B1};
    endfunction

    function automatic int dval(input int dm);
        case (dm)
            0: return 1;
            1: return 4;
            2: return 5;
            3: return 10;
            4: return 11;
            default: return 0;
        endcase
    endfunction

    // Source memory: data for each request appears LAT cycles later
    logic [LAT-1:0] rv = '0;
    logic [AW-1:0]  ra [LAT];
    always @(posedge clk) begin
        rv <= {rv[LAT-2:0], mem_rd_req};
        ra[0] <= mem_rd_addr;
        for (int i = 1; i < LAT; i++) ra[i] <= ra[i-1];
    end
    assign mem_rd_data = rv[LAT-1] ? fdata(ra[LAT-1]) : 64'hDEAD_BEEF_0BAD_F00D;

    always @(posedge clk) begin
        #1;
        dp_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
    end

    logic [AW-1:0] req_q[$];
    logic [63:0]   got_q[$];
    int first_req, first_val, n_en, en_cyc, n_done, done_cyc;
    int n_err, err_cyc, n_busy, n_unstable, n_busy_done, max_out;
    logic [AW-1:0] en_dest;
    logic          hold_pend;
    logic [63:0]   hold_data;

    task automatic clear_mon();
        req_q.delete();
        got_q.delete();
        first_req = -1; first_val = -1; n_en = 0; en_cyc = -1;
        n_done = 0; done_cyc = -1; n_err = 0; err_cyc = -1;
        n_busy = 0; n_unstable = 0; n_busy_done = 0; max_out = 0;
        en_dest = '0; hold_pend = 1'b0; hold_data = '0;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_rd_req) begin
                req_q.push_back(mem_rd_addr);
                if (first_req < 0) first_req = cyc;
            end
            if (dp_enable) begin
                n_en++;
                en_cyc = cyc;
                en_dest = dp_dest_addr;
            end
            if (dp_valid) begin
                if (first_val < 0) first_val = cyc;
                if (hold_pend && dp_data !== hold_data) n_unstable++;
            end else if (hold_pend) begin
                n_unstable++;
            end
            hold_pend = dp_valid && !dp_ready;
            hold_data = dp_data;
            if (dp_valid && dp_ready) got_q.push_back(dp_data);
            if (done) begin
                n_done++;
                done_cyc = cyc;
                if (busy) n_busy_done++;
            end
            if (error) begin
                n_err++;
                err_cyc = cyc;
            end
            if (busy) n_busy++;
            if (req_q.size() - got_q.size() > max_out) max_out = req_q.size() - got_q.size();
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int np, input int dm, input logic [AW-1:0] src,
                           input logic [AW-1:0] dest, input int pct, input bit extra);
        int tot, t0, td, k, nb;
        logic [AW-1:0] ea;
        tot = np * 4 * dval(dm);
        rdy_pct = pct;
        tick();
        clear_mon();
        start = 1'b1; num_poly = 3'(np); d_mode = 3'(dm);
        src_base_addr = src; dest_base_addr = dest;
        t0 = cyc;
        tick();
        start = 1'b0;
        k = 0;
        while (got_q.size() < tot && k < 4000) begin
            start = extra && (k == 10);
            tick();
            k++;
        end
        start = 1'b0;
        chk("job_timeout", 64'(k < 4000), 64'd1);
        repeat (2) tick();
        dp_done = 1'b1;
        td = cyc;
        tick();
        dp_done = 1'b0;
        repeat (2) tick();
        chk("en_count", 64'(n_en), 64'd1);
        chk("en_cycle", 64'(en_cyc), 64'(t0 + 1));
        chk("en_dest", 64'(en_dest), 64'(dest));
        chk("first_req", 64'(first_req), 64'(t0 + 2));
        if (pct >= 100) chk("first_valid", 64'(first_val), 64'(t0 + 2 + LAT));
        chk("req_count", 64'(req_q.size()), 64'(tot));
        chk("word_count", 64'(got_q.size()), 64'(tot));
        nb = 0;
        for (int i = 0; i < tot && i < req_q.size() && i < got_q.size(); i++) begin
            ea = src + AW'(i);
            if (req_q[i] !== ea) nb++;
            if (got_q[i] !== fdata(ea)) nb++;
        end
        chk("stream_mismatches", 64'(nb), 64'd0);
        chk("done_count", 64'(n_done), 64'd1);
        chk("done_cycle", 64'(done_cyc), 64'(td + 1));
        chk("busy_at_done", 64'(n_busy_done), 64'd0);
        chk("err_count", 64'(n_err), 64'd0);
        chk("valid_unstable", 64'(n_unstable), 64'd0);
        chk("credit_bound", 64'(max_out <= DEPTH), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        if (pct >= 100) chk("no_bubbles", 64'(done_cyc - td), 64'd1);
    endtask

    task automatic bad_cmd(input int np, input int dm);
        int t0;
        tick();
        clear_mon();
        start = 1'b1; num_poly = 3'(np); d_mode = 3'(dm);
        t0 = cyc;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("illegal_err_count", 64'(n_err), 64'd1);
        chk("illegal_err_cycle", 64'(err_cyc), 64'(t0 + 1));
        chk("illegal_reqs", 64'(req_q.size()), 64'd0);
        chk("illegal_enable", 64'(n_en), 64'd0);
        chk("illegal_busy", 64'(n_busy), 64'd0);
    endtask

    initial begin
        int k, ti;
        clear_mon();
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req", 64'(mem_rd_req), 64'd0);
        chk("rst_valid", 64'(dp_valid), 64'd0);
        chk("rst_outs", 64'({dp_enable, done, error}), 64'd0);
        chk("rst_addr", 64'(mem_rd_addr), 64'd0);
        chk("rst_dest", 64'(dp_dest_addr), 64'd0);
        chk("rst_data", dp_data, 64'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        run_job(1, 0, 14'h0100, 14'h02A0, 100, 1'b0);
        run_job(4, 4, AW'($urandom), AW'($urandom), 100, 1'b1);
        run_job(2, 3, AW'($urandom), AW'($urandom), 30, 1'b0);

        bad_cmd(0, 1);
        bad_cmd(2, 7);
        bad_cmd(5, 0);

        // Zeroize partway through a d5 job
        rdy_pct = 100;
        tick();
        clear_mon();
        start = 1'b1; num_poly = 3'd1; d_mode = 3'd2;
        src_base_addr = 14'h0400; dest_base_addr = 14'h0155;
        tick();
        start = 1'b0;
        k = 0;
        while (got_q.size() < 10 && k < 200) begin
            tick();
            k++;
        end
        chk("zero_reach10", 64'(k < 200), 64'd1);
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("zero_busy", 64'(busy), 64'd0);
        chk("zero_req", 64'(mem_rd_req), 64'd0);
        chk("zero_valid", 64'(dp_valid), 64'd0);
        chk("zero_pulses", 64'({dp_enable, done, error}), 64'd0);
        chk("zero_addrs", 64'({mem_rd_addr, dp_dest_addr}), 64'd0);
        chk("zero_data", dp_data, 64'd0);
        clear_mon();
        repeat (10) tick();
        chk("zero_late_words", 64'(got_q.size()), 64'd0);
        chk("zero_late_reqs", 64'(req_q.size()), 64'd0);
        run_job(1, 2, 14'h0800, 14'h0033, 100, 1'b0);

        // Completion reported while words are still streaming
        rdy_pct = 50;
        tick();
        clear_mon();
        start = 1'b1; num_poly = 3'd2; d_mode = 3'd1;
        src_base_addr = 14'h1000; dest_base_addr = 14'h0777;
        tick();
        start = 1'b0;
        repeat (8) tick();
        dp_done = 1'b1;
        ti = cyc;
        tick();
        dp_done = 1'b0;
        chk("perr_error", 64'(error), 64'd1);
        chk("perr_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        chk("perr_err_cycle", 64'(err_cyc), 64'(ti + 1));
        chk("perr_err_count", 64'(n_err), 64'd1);
        chk("perr_no_done", 64'(n_done), 64'd0);
        clear_mon();
        repeat (10) tick();
        chk("perr_quiet", 64'(req_q.size() + got_q.size()), 64'd0);

        for (int j = 0; j < 3; j++) begin
            run_job(int'($urandom_range(4, 1)), int'($urandom_range(4, 0)),
                    AW'($urandom), AW'($urandom), int'($urandom_range(100, 20)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
